// File: rtl/fb_pkg.sv
// Shared constants and types for the frame buffer read path.
package fb_pkg;

  localparam logic ASSERT   = 1'b0;
  localparam logic DEASSERT = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fb_state_t;

endpackage

// File: rtl/fb_rd_fifo.sv
// Small synchronous output FIFO with registered head, valid and count.
module fb_rd_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_do_push, w_do_pop;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_kept, w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_do_pop     = i_pop && (r_count != '0);
  assign w_do_push    = i_push && ((r_count != FULL) || w_do_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_do_pop);
  assign w_kept       = r_count - CW'(w_do_pop);
  assign w_count_nxt  = w_kept + CW'(w_do_push);

  // The head register is loaded with whatever becomes the oldest entry after
  // this cycle's pop/push, so the output never waits on a RAM read.
  always_comb begin
    w_head_nxt = r_head;
    if (w_kept == '0) begin
      if (w_do_push) w_head_nxt = i_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_do_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != '0);
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/fb_reader.sv
// Frame buffer read sequencer: issues wrapped address runs, absorbs the
// one-cycle memory latency and streams words out with valid/ready.
module fb_reader
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int RW = ADDR_WIDTH + 1;

  fb_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
  logic [RW-1:0]         r_remaining;
  logic                  r_mem_rd_en;
  logic                  r_cap;
  logic                  r_busy;
  logic                  r_done_zero;

  logic [CW-1:0]         w_fifo_count;
  logic [1:0]            w_outstanding;
  logic                  w_pop, w_issue, w_final_pop;

  // Stage 0 is the read strobe itself, stage 1 marks the data-valid cycle.
  assign w_outstanding = {1'b0, (r_mem_rd_en == ASSERT)} + {1'b0, r_cap};
  assign w_pop         = out_valid & out_ready;
  assign w_issue       = (r_state == RUN) && (r_remaining != '0) &&
                         ((SW'(w_fifo_count) + SW'(w_outstanding)) < SW'(FIFO_DEPTH));
  assign w_final_pop   = (r_state == DRAIN) && (w_outstanding == 2'd0) &&
                         (w_fifo_count == CW'(1)) && w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_mem_rd_addr <= '0;
      r_remaining   <= '0;
      r_mem_rd_en   <= DEASSERT;
      r_cap         <= 1'b0;
      r_busy        <= 1'b0;
      r_done_zero   <= 1'b0;
    end else begin
      r_cap       <= (r_mem_rd_en == ASSERT);
      r_mem_rd_en <= DEASSERT;
      r_done_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done_zero <= 1'b1;
            end else begin
              // First read goes out straight from IDLE so it lands in T+1.
              r_state       <= RUN;
              r_busy        <= 1'b1;
              r_mem_rd_en   <= ASSERT;
              r_mem_rd_addr <= start_addr;
              r_addr        <= start_addr + 1'b1;
              r_remaining   <= len - 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_mem_rd_en   <= ASSERT;
            r_mem_rd_addr <= r_addr;
            r_addr        <= r_addr + 1'b1;
            r_remaining   <= r_remaining - 1'b1;
            if (r_remaining == RW'(1)) r_state <= DRAIN;
          end else if (r_remaining == '0) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_final_pop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fb_rd_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_cap),
    .i_data (mem_rd_data),
    .i_pop  (w_pop),
    .o_data (out_data),
    .o_valid(out_valid),
    .o_count(w_fifo_count)
  );

  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign busy        = r_busy;
  // The run-complete pulse coincides with the final handshake, so it is
  // gated by out_ready; every other term is a register.
  assign done        = r_done_zero | w_final_pop;

endmodule
